// File: rtl/onion_gpio_edge_irq_if.sv
// Wishbone slave bus bundle for onion_gpio_edge_irq.
//   master : address decoder / bus side (drives address, strobes, write data)
//   slave  : the GPIO edge IRQ block (drives read data and acknowledge)
// Signals:
//   WBs_ADR_i       byte address inside the module aperture
//   WBs_CYC_i       decoded chip select
//   WBs_STB_i       transfer strobe
//   WBs_WE_i        1 = write
//   WBs_BYTE_STB_i  write byte enables
//   WBs_DAT_i       write data
//   WBs_DAT_o       read data, valid while WBs_ACK_o = 1
//   WBs_ACK_o       single-cycle acknowledge
interface onion_gpio_edge_irq_if #(
  parameter int ADDRWIDTH = 10
);
  logic [ADDRWIDTH-1:0] WBs_ADR_i;
  logic                 WBs_CYC_i;
  logic                 WBs_STB_i;
  logic                 WBs_WE_i;
  logic [3:0]           WBs_BYTE_STB_i;
  logic [31:0]          WBs_DAT_i;
  logic [31:0]          WBs_DAT_o;
  logic                 WBs_ACK_o;

  modport master (
    output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    input  WBs_DAT_o, WBs_ACK_o
  );

  modport slave (
    input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    output WBs_DAT_o, WBs_ACK_o
  );
endinterface

// File: rtl/onion_gpio_edge_irq.sv
// onion_gpio_edge_irq
// Debounced GPIO input capture with rise/fall edge detection, sticky W1C
// status and a masked, registered level interrupt, behind a Wishbone slave.
//
// Ports:
//   WBs_CLK_i   single clock
//   WBs_RST_i   asynchronous active-low reset
//   wb          Wishbone slave bundle (onion_gpio_edge_irq_if.slave)
//   GPIO_IN_i   asynchronous pad inputs, NUM_PINS wide
//   IRQ_o       level interrupt, active-high: |(STATUS & MASK), one cycle late
//
// Register map (byte offset):
//   0x00 RAW     RO   synchronised inputs
//   0x04 DEB     RO   debounced inputs
//   0x08 RISE_EN RW
//   0x0C FALL_EN RW
//   0x10 STATUS  RO / write-1-to-clear
//   0x14 MASK    RW
//   0x18 DEB_THR RW   [DEB_WIDTH-1:0]
//   0x1C TSTAMP  RO   only with ONION_GPIO_EDGE_TIMESTAMP_EN defined
//   others read DEF_REG_VALUE, writes dropped
//
// Build option: define ONION_GPIO_EDGE_TIMESTAMP_EN to add a free-running
// 32-bit cycle counter that is captured into TSTAMP whenever a STATUS bit sets.
module onion_gpio_edge_irq #(
  parameter int          NUM_PINS      = 8,
  parameter int          ADDRWIDTH     = 10,
  parameter int          DEB_WIDTH     = 16,
  parameter logic [31:0] DEF_REG_VALUE = 32'hDEF_FAB_AC
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RST_i,
  onion_gpio_edge_irq_if.slave  wb,
  input  logic [NUM_PINS-1:0]   GPIO_IN_i,
  output logic                  IRQ_o
);

  localparam int AW = ADDRWIDTH - 2;

  localparam logic [AW-1:0] IDX_RAW    = AW'(0);
  localparam logic [AW-1:0] IDX_DEB    = AW'(1);
  localparam logic [AW-1:0] IDX_RISE   = AW'(2);
  localparam logic [AW-1:0] IDX_FALL   = AW'(3);
  localparam logic [AW-1:0] IDX_STATUS = AW'(4);
  localparam logic [AW-1:0] IDX_MASK   = AW'(5);
  localparam logic [AW-1:0] IDX_THR    = AW'(6);
`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
  localparam logic [AW-1:0] IDX_TSTAMP = AW'(7);
`endif

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] lane_m);
    return (old_v & ~lane_m) | (new_v & lane_m);
  endfunction

  logic [NUM_PINS-1:0]  sync1_q, sync1_d;
  logic [NUM_PINS-1:0]  raw_q, raw_d;
  logic [NUM_PINS-1:0]  deb_q, deb_d;
  logic [NUM_PINS-1:0]  deb_prev_q, deb_prev_d;
  logic [DEB_WIDTH-1:0] cnt_q [NUM_PINS];
  logic [DEB_WIDTH-1:0] cnt_d [NUM_PINS];
  logic [NUM_PINS-1:0]  rise_en_q, rise_en_d;
  logic [NUM_PINS-1:0]  fall_en_q, fall_en_d;
  logic [NUM_PINS-1:0]  status_q, status_d;
  logic [NUM_PINS-1:0]  mask_q, mask_d;
  logic [DEB_WIDTH-1:0] thr_q, thr_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 irq_q, irq_d;
`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
  logic [31:0]          ts_cnt_q, ts_cnt_d;
  logic [31:0]          tstamp_q, tstamp_d;
`endif

  logic [AW-1:0]        reg_idx;
  logic [31:0]          be_mask;
  logic                 access, wr_en, rd_en;
  logic [NUM_PINS-1:0]  edge_set, w1c;
  logic [31:0]          rd_val;
  logic                 unused_adr;

  assign reg_idx    = wb.WBs_ADR_i[ADDRWIDTH-1:2];
  assign unused_adr = ^wb.WBs_ADR_i[1:0];
  assign be_mask    = {{8{wb.WBs_BYTE_STB_i[3]}}, {8{wb.WBs_BYTE_STB_i[2]}},
                       {8{wb.WBs_BYTE_STB_i[1]}}, {8{wb.WBs_BYTE_STB_i[0]}}};

  // The transfer is accepted on the edge that raises ACK; the ~ack_q term
  // makes a held strobe acknowledge every other cycle.
  assign access = wb.WBs_CYC_i & wb.WBs_STB_i & ~ack_q;
  assign wr_en  = access & wb.WBs_WE_i;
  assign rd_en  = access & ~wb.WBs_WE_i;

  always_comb begin
    sync1_d    = GPIO_IN_i;
    raw_d      = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < NUM_PINS; i++) begin
      cnt_d[i] = '0;
      if (raw_q[i] != deb_q[i]) begin
        // >= so that lowering the threshold mid-count cannot strand a pin
        if (cnt_q[i] >= thr_q) deb_d[i] = raw_q[i];
        else                   cnt_d[i] = cnt_q[i] + DEB_WIDTH'(1);
      end
    end
  end

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    thr_d     = thr_q;
    w1c       = '0;
    if (wr_en) begin
      case (reg_idx)
        IDX_RISE:   rise_en_d = NUM_PINS'(merge_lanes(32'(rise_en_q), wb.WBs_DAT_i, be_mask));
        IDX_FALL:   fall_en_d = NUM_PINS'(merge_lanes(32'(fall_en_q), wb.WBs_DAT_i, be_mask));
        IDX_MASK:   mask_d    = NUM_PINS'(merge_lanes(32'(mask_q), wb.WBs_DAT_i, be_mask));
        IDX_THR:    thr_d     = DEB_WIDTH'(merge_lanes(32'(thr_q), wb.WBs_DAT_i, be_mask));
        IDX_STATUS: w1c       = NUM_PINS'(wb.WBs_DAT_i & be_mask);
        default:    ;
      endcase
    end
    edge_set = (deb_q & ~deb_prev_q & rise_en_q) | (~deb_q & deb_prev_q & fall_en_q);
    // set after clear: a new edge survives a simultaneous W1C
    status_d = (status_q & ~w1c) | edge_set;
    irq_d    = |(status_q & mask_q);
  end

`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
  always_comb begin
    ts_cnt_d = ts_cnt_q + 32'd1;
    tstamp_d = (|edge_set) ? ts_cnt_q : tstamp_q;
  end
`endif

  always_comb begin
    rd_val = DEF_REG_VALUE;
    case (reg_idx)
      IDX_RAW:    rd_val = 32'(raw_q);
      IDX_DEB:    rd_val = 32'(deb_q);
      IDX_RISE:   rd_val = 32'(rise_en_q);
      IDX_FALL:   rd_val = 32'(fall_en_q);
      IDX_STATUS: rd_val = 32'(status_q);
      IDX_MASK:   rd_val = 32'(mask_q);
      IDX_THR:    rd_val = 32'(thr_q);
`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
      IDX_TSTAMP: rd_val = tstamp_q;
`endif
      default:    ;
    endcase
    ack_d = access;
    dat_d = rd_en ? rd_val : 32'd0;
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
    if (!WBs_RST_i) begin
      sync1_q    <= '0;
      raw_q      <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      thr_q      <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
      ts_cnt_q   <= '0;
      tstamp_q   <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      raw_q      <= raw_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= cnt_d[i];
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      thr_q      <= thr_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
      ts_cnt_q   <= ts_cnt_d;
      tstamp_q   <= tstamp_d;
`endif
    end
  end

  assign wb.WBs_ACK_o = ack_q;
  assign wb.WBs_DAT_o = dat_q;
  assign IRQ_o        = irq_q;

endmodule

// File: tb/tb_onion_gpio_edge_irq.sv
`timescale 1ns/1ps
module tb_onion_gpio_edge_irq;
  localparam int          NUM_PINS = 8;
  localparam logic [31:0] DEF_VAL  = 32'hDEFFABAC;

  logic                WBs_CLK_i = 1'b0;
  logic                WBs_RST_i = 1'b0;
  logic [NUM_PINS-1:0] gpio      = '0;
  logic                irq;

  int n_checks = 0;
  int n_errors = 0;

  onion_gpio_edge_irq_if #(.ADDRWIDTH(10)) wb_if ();

  onion_gpio_edge_irq #(
    .NUM_PINS(NUM_PINS), .ADDRWIDTH(10), .DEB_WIDTH(16), .DEF_REG_VALUE(32'hDEF_FAB_AC)
  ) dut (
    .WBs_CLK_i (WBs_CLK_i),
    .WBs_RST_i (WBs_RST_i),
    .wb        (wb_if),
    .GPIO_IN_i (gpio),
    .IRQ_o     (irq)
  );

  always #5 WBs_CLK_i = ~WBs_CLK_i;

`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
  int edges_since_rst = 0;
  always @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) edges_since_rst = edges_since_rst + 1;
    else           edges_since_rst = 0;
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge WBs_CLK_i);
    #1;
  endtask

  task automatic bus_idle();
    wb_if.WBs_CYC_i      = 1'b0;
    wb_if.WBs_STB_i      = 1'b0;
    wb_if.WBs_WE_i       = 1'b0;
    wb_if.WBs_BYTE_STB_i = 4'h0;
    wb_if.WBs_ADR_i      = '0;
    wb_if.WBs_DAT_i      = '0;
  endtask

  task automatic bus_drive(input logic [9:0] adr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdat);
    wb_if.WBs_CYC_i      = 1'b1;
    wb_if.WBs_STB_i      = 1'b1;
    wb_if.WBs_WE_i       = we;
    wb_if.WBs_BYTE_STB_i = be;
    wb_if.WBs_ADR_i      = adr;
    wb_if.WBs_DAT_i      = wdat;
  endtask

  // One access: ACK must come on the first edge and last exactly one cycle.
  task automatic wb_access(input logic [9:0] adr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdat, output logic [31:0] rdat);
    int waits = 0;
    bus_drive(adr, we, be, wdat);
    tick();
    while (!wb_if.WBs_ACK_o && waits < 4) begin
      tick();
      waits++;
    end
    check("ack_latency", 32'(waits), 32'd0);
    rdat = wb_if.WBs_DAT_o;
    bus_idle();
    tick();
    check("ack_width", 32'(wb_if.WBs_ACK_o), 32'd0);
  endtask

  task automatic wr(input logic [9:0] adr, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(adr, 1'b1, be, d, dummy);
  endtask

  task automatic rd(input logic [9:0] adr, output logic [31:0] d);
    wb_access(adr, 1'b0, 4'h0, 32'd0, d);
  endtask

  task automatic do_reset();
    bus_idle();
    gpio      = '0;
    WBs_RST_i = 1'b0;
    repeat (3) tick();
    WBs_RST_i = 1'b1;
    tick();
  endtask

  logic [31:0]         rv;
  logic [3:0]          ack_pat;
  int                  first_irq;
  logic [NUM_PINS-1:0] m_deb, m_status, m_rise, m_fall, m_mask, cur, newv, c;
  int                  thr, w, persist, sel;
  logic [3:0]          be;
  logic [31:0]         clr;

  initial begin
    bus_idle();
    do_reset();

    // reset state
    check("rst_ack", 32'(wb_if.WBs_ACK_o), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    for (int off = 0; off < 7; off++) begin
      rd(10'(off * 4), rv);
      check($sformatf("rst_reg_%02h", off * 4), rv, 32'd0);
    end
    rd(10'h20, rv); check("rst_undef_20", rv, DEF_VAL);
    rd(10'h1C, rv);
`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
    check("rst_tstamp", rv, 32'd0);
`else
    check("undef_1c", rv, DEF_VAL);
`endif

    // byte lanes, RO/undefined writes, width clipping
    wr(10'h14, 4'b0001, 32'h1234_56A5); rd(10'h14, rv); check("mask_lane0", rv, 32'h0000_00A5);
    wr(10'h14, 4'b0000, 32'h0000_005A); rd(10'h14, rv); check("mask_no_lane", rv, 32'h0000_00A5);
    wr(10'h14, 4'b1111, 32'hFFFF_FF3C); rd(10'h14, rv); check("mask_clip", rv, 32'h0000_003C);
    wr(10'h18, 4'b1111, 32'hFFFF_FFFF); rd(10'h18, rv); check("thr_clip", rv, 32'h0000_FFFF);
    wr(10'h20, 4'b1111, 32'h1111_1111); rd(10'h20, rv); check("undef_wr_drop", rv, DEF_VAL);
    wr(10'h00, 4'b1111, 32'hFFFF_FFFF); rd(10'h00, rv); check("raw_ro", rv, 32'd0);
    rd(10'h22, rv); check("adr_low_bits_ignored", rv, DEF_VAL);

    // held strobe acknowledges every other cycle
    bus_drive(10'h14, 1'b0, 4'h0, 32'd0);
    for (int k = 3; k >= 0; k--) begin
      tick();
      ack_pat[k] = wb_if.WBs_ACK_o;
    end
    bus_idle();
    tick();
    check("b2b_ack_pattern", 32'(ack_pat), 32'h0000_000A);

    // CYC dropped before the edge: no ACK, no write
    bus_drive(10'h14, 1'b1, 4'hF, 32'd0);
    #3;
    bus_idle();
    tick();
    check("abort_no_ack", 32'(wb_if.WBs_ACK_o), 32'd0);
    rd(10'h14, rv); check("abort_no_write", rv, 32'h0000_003C);

    // input-to-IRQ latency: DEB at 7, STATUS at 8, IRQ at 9 for DEB_THR=4
    do_reset();
    wr(10'h18, 4'hF, 32'd4);
    wr(10'h08, 4'hF, 32'h01);
    wr(10'h14, 4'hF, 32'h01);
    gpio[0]   = 1'b1;
    first_irq = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (irq && first_irq == 0) first_irq = k;
    end
    check("irq_latency", 32'(first_irq), 32'd9);
    rd(10'h04, rv); check("deb_after_rise", rv, 32'h01);
    rd(10'h10, rv); check("status_after_rise", rv, 32'h01);

    // glitch of DEB_THR cycles is rejected, DEB_THR+1 is accepted
    wr(10'h08, 4'hF, 32'h09);
    gpio[3] = 1'b1; repeat (4) tick(); gpio[3] = 1'b0; repeat (12) tick();
    rd(10'h10, rv); check("glitch_4_rejected", rv, 32'h01);
    gpio[3] = 1'b1; repeat (5) tick(); gpio[3] = 1'b0; repeat (12) tick();
    rd(10'h10, rv); check("glitch_5_accepted", rv, 32'h09);
    rd(10'h04, rv); check("deb_after_glitches", rv, 32'h01);

    // async reset in the middle of an ACK
    check("irq_before_rst", 32'(irq), 32'd1);
    bus_drive(10'h04, 1'b0, 4'h0, 32'd0);
    tick();
    check("ack_before_rst", 32'(wb_if.WBs_ACK_o), 32'd1);
    #2 WBs_RST_i = 1'b0;
    #1;
    check("rst_async_ack", 32'(wb_if.WBs_ACK_o), 32'd0);
    check("rst_async_irq", 32'(irq), 32'd0);
    bus_idle();
    do_reset();

    // W1C collides with a fresh falling edge: the set wins
    do_reset();
    wr(10'h18, 4'hF, 32'd1);
    wr(10'h0C, 4'hF, 32'h02);
    wr(10'h14, 4'hF, 32'h02);
    gpio[1] = 1'b1; repeat (10) tick();
    rd(10'h10, rv); check("rise_no_fall_status", rv, 32'h00);
    gpio[1] = 1'b0; repeat (10) tick();
    rd(10'h10, rv); check("fall_status", rv, 32'h02);
    gpio[1] = 1'b1; repeat (10) tick();
    gpio[1] = 1'b0;
    repeat (4) tick();                // STATUS sets on the 5th edge (thr+4)
    wr(10'h10, 4'hF, 32'h02);         // commits on that same 5th edge
    rd(10'h10, rv); check("set_wins_w1c", rv, 32'h02);
    check("irq_set_wins", 32'(irq), 32'd1);
    bus_drive(10'h10, 1'b1, 4'hF, 32'h02);
    tick();
    check("irq_lags_clear", 32'(irq), 32'd1);
    bus_idle();
    tick();
    check("irq_after_clear", 32'(irq), 32'd0);
    rd(10'h10, rv); check("status_cleared", rv, 32'h00);

    // lowering DEB_THR mid-count releases the pin immediately
    do_reset();
    wr(10'h18, 4'b0011, 32'd100);
    gpio[2] = 1'b1;
    repeat (52) tick();
    wr(10'h18, 4'b0011, 32'd2);
    rd(10'h04, rv); check("thr_lower_no_stall", rv, 32'h04);

`ifdef ONION_GPIO_EDGE_TIMESTAMP_EN
    begin
      int n0;
      do_reset();
      wr(10'h18, 4'hF, 32'd0);
      wr(10'h08, 4'hF, 32'h01);
      n0      = edges_since_rst;
      gpio[0] = 1'b1;
      repeat (10) tick();
      rd(10'h1C, rv); check("tstamp_capture", rv, 32'(n0 + 3));
    end
`endif

    // randomized trials against a settled-state model
    do_reset();
    m_deb = '0; m_status = '0; cur = '0;
    for (int t = 0; t < 40; t++) begin
      thr    = int'($urandom_range(0, 5));
      m_rise = NUM_PINS'($urandom);
      m_fall = NUM_PINS'($urandom);
      m_mask = NUM_PINS'($urandom);
      wr(10'h18, 4'hF, 32'(thr));
      wr(10'h08, 4'hF, 32'(m_rise));
      wr(10'h0C, 4'hF, 32'(m_fall));
      wr(10'h14, 4'hF, 32'(m_mask));
      newv    = NUM_PINS'($urandom);
      sel     = int'($urandom_range(0, 2));
      w       = (sel == 0) ? thr : (sel == 1) ? thr + 1 : int'($urandom_range(1, 8));
      if (w < 1) w = 1;
      persist = int'($urandom_range(0, 1));
      gpio = newv;
      repeat (w) tick();
      if (persist == 0) gpio = cur;
      repeat (thr + 10) tick();
      c = cur ^ newv;
      if (persist != 0) begin
        m_status = m_status | (c & newv & m_rise) | (c & ~newv & m_fall);
        m_deb    = newv;
        cur      = newv;
      end else if (w >= thr + 1) begin
        m_status = m_status | (c & (m_rise | m_fall));
      end
      rd(10'h00, rv); check($sformatf("rnd%0d_raw", t), rv, 32'(cur));
      rd(10'h04, rv); check($sformatf("rnd%0d_deb", t), rv, 32'(m_deb));
      rd(10'h10, rv); check($sformatf("rnd%0d_status", t), rv, 32'(m_status));
      check($sformatf("rnd%0d_irq", t), 32'(irq), 32'(|(m_status & m_mask)));
      if ($urandom_range(0, 1) == 1) begin
        be  = 4'($urandom);
        clr = $urandom;
        wr(10'h10, be, clr);
        if (be[0]) m_status = m_status & ~clr[NUM_PINS-1:0];
        rd(10'h10, rv); check($sformatf("rnd%0d_w1c", t), rv, 32'(m_status));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
